divider: RTL and testbench

//  Multi-cycle restoring integer divider, the inverse companion of the team's sequential multiplier.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_step.sv | 23 ++
 rtl/divider.sv | 142 ++++++++++++++
 tb/tb_divider.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared state encoding, default width and sizing helper for the sequential divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Smallest n with 2**n >= value; sizes the iteration counter.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift a dividend bit into the partial remainder,
// trial-subtract the divisor and keep the difference only when it does not go negative.
module div_step import div_pkg::*; #(
  parameter int unsigned WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] r,
  input  logic             din,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] r_next_c,
  output logic             qbit_c
);

  // The incoming remainder is always below the divisor, so the shifted trial value
  // needs one extra bit and the restored result fits back into WIDTH bits.
  logic [WIDTH:0] shifted;

  always_comb begin
    shifted  = {r, din};
    qbit_c   = (shifted >= {1'b0, dvs});
    r_next_c = qbit_c ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/divider.sv
// Sequential restoring divider: quo/rem of op1/op2 after exactly WIDTH cycles, en/val handshake.
// Define DIVIDER_SIGNED_EN for two's-complement signed division (truncating toward zero).
module divider import div_pkg::*; #(
  parameter int unsigned WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             ready,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             val,
  output logic             overflow
);

  localparam int unsigned      CNT_W    = (clog2(WIDTH) > 0) ? clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;   // dividend bits leave at the top, quotient bits enter at the bottom
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic             ovf_q;

  logic             accept_c;
  logic [WIDTH-1:0] op1_mag_c;
  logic [WIDTH-1:0] op2_mag_c;
  logic             ovf_c;
  logic [WIDTH-1:0] step_r_c;
  logic             step_q_c;
  logic [WIDTH-1:0] q_fin_c;
  logic [WIDTH-1:0] quo_fix_c;
  logic [WIDTH-1:0] rem_fix_c;

  assign accept_c = en & ready;
  assign q_fin_c  = {dvd[WIDTH-2:0], step_q_c};

  div_step #(.WIDTH(WIDTH)) u_step (
    .r        (prem),
    .din      (dvd[WIDTH-1]),
    .dvs      (dvs),
    .r_next_c (step_r_c),
    .qbit_c   (step_q_c)
  );

`ifdef DIVIDER_SIGNED_EN
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  logic neg_q;
  logic neg_r;
  logic dz_q;

  // Divide magnitudes; MIN_INT's magnitude is representable as an unsigned value.
  always_comb begin
    op1_mag_c = op1[WIDTH-1] ? -op1 : op1;
    op2_mag_c = op2[WIDTH-1] ? -op2 : op2;
    ovf_c     = (op2 == '0) || ((op1 == MIN_INT) && (op2 == '1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz_q  <= 1'b0;
    end else if (accept_c) begin
      neg_q <= op1[WIDTH-1] ^ op2[WIDTH-1];
      neg_r <= op1[WIDTH-1];
      dz_q  <= (op2 == '0);
    end
  end

  // A zero divisor reports -1 regardless of signs; the remainder restores op1 exactly.
  always_comb begin
    quo_fix_c = dz_q ? '1 : (neg_q ? -q_fin_c : q_fin_c);
    rem_fix_c = neg_r ? -step_r_c : step_r_c;
  end
`else
  always_comb begin
    op1_mag_c = op1;
    op2_mag_c = op2;
    ovf_c     = (op2 == '0);
    quo_fix_c = q_fin_c;
    rem_fix_c = step_r_c;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      prem     <= '0;
      ovf_q    <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      val      <= 1'b0;
      overflow <= 1'b0;
      ready    <= 1'b1;
    end else begin
      val <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept_c) begin
            dvd   <= op1_mag_c;
            dvs   <= op2_mag_c;
            prem  <= '0;
            ovf_q <= ovf_c;
            cnt   <= CNT_LAST;
            ready <= 1'b0;
            state <= ST_CALC;
          end else begin
            ready <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          prem <= step_r_c;
          dvd  <= q_fin_c;
          if (cnt == '0) begin
            quo      <= quo_fix_c;
            rem      <= rem_fix_c;
            overflow <= ovf_q;
            val      <= 1'b1;
            ready    <= 1'b1;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: expected results queue up at issue and are checked
// (values plus fixed latency) whenever val pulses.
`timescale 1ns/1ps
module tb_divider;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic         ready;
  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic         val;
  logic         overflow;

  typedef struct {
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         ovf;
    int           acc;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_val = 0;

  divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .op1      (op1),
    .op2      (op2),
    .ready    (ready),
    .quo      (quo),
    .rem      (rem),
    .val      (val),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor: every val pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && val === 1'b1) begin
      n_val++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_val: val=1 at cycle %0d, required no pending result", cyc);
      end else begin
        e = sb.pop_front();
        if (quo !== e.quo) begin
          bad++;
          $display("FAIL %s_quo: got %h, required %h", e.name, quo, e.quo);
        end
        total++;
        if (rem !== e.rem) begin
          bad++;
          $display("FAIL %s_rem: got %h, required %h", e.name, rem, e.rem);
        end
        total++;
        if (overflow !== e.ovf) begin
          bad++;
          $display("FAIL %s_ovf: got %b, required %b", e.name, overflow, e.ovf);
        end
        total++;
        if ((cyc - e.acc) !== int'(W)) begin
          bad++;
          $display("FAIL %s_latency: got %0d, required %0d", e.name, cyc - e.acc, W);
        end
      end
    end
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.acc  = 0;
    e.name = "rand";
    if (b == '0) begin
      e.quo = '1;
      e.rem = a;
      e.ovf = 1'b1;
    end
`ifdef DIVIDER_SIGNED_EN
    else if (a == 32'h8000_0000 && b == '1) begin
      e.quo = a;
      e.rem = '0;
      e.ovf = 1'b1;
    end else begin
      e.quo = W'($signed(a) / $signed(b));
      e.rem = W'($signed(a) % $signed(b));
      e.ovf = 1'b0;
    end
`else
    else begin
      e.quo = a / b;
      e.rem = a % b;
      e.ovf = 1'b0;
    end
`endif
    return e;
  endfunction

  // Called at a negedge: waits for ready, holds en for one cycle, then scrambles the operands.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic eo, input string name);
    exp_t e;
    int   k;
    k = 0;
    while (ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s_ready_timeout: ready=%b, required 1", name, ready);
      return;
    end
    en  = 1'b1;
    op1 = a;
    op2 = b;
    e.quo  = eq;
    e.rem  = er;
    e.ovf  = eo;
    e.acc  = cyc + 1;
    e.name = name;
    sb.push_back(e);
    @(negedge clk);
    en  = 1'b0;
    op1 = $urandom();
    op2 = $urandom();
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_result_timeout: pending=%0d, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_val(input string name);
    int k;
    k = 0;
    while (val !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (val !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s_val_timeout: val=%b, required 1", name, val);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b0;
    op1   = '0;
    op2   = '0;
    repeat (2) @(negedge clk);
    total++; if (ready !== 1'b1)  begin bad++; $display("FAIL reset_ready: got %b, required 1", ready); end
    total++; if (val !== 1'b0)    begin bad++; $display("FAIL reset_val: got %b, required 0", val); end
    total++; if (quo !== '0)      begin bad++; $display("FAIL reset_quo: got %h, required 0", quo); end
    total++; if (rem !== '0)      begin bad++; $display("FAIL reset_rem: got %h, required 0", rem); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b, required 0", overflow); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    issue(32'd2688, 32'd56, 32'd48, 32'd0, 1'b0, "div_2688_56");
    wait_done("div_2688_56");
  endtask

  task automatic test_hold();
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "div_100_7");
    wait_val("div_100_7");
    @(negedge clk);
    total++; if (val !== 1'b0)   begin bad++; $display("FAIL hold_val_pulse: got %b, required 0", val); end
    total++; if (quo !== 32'd14) begin bad++; $display("FAIL hold_quo: got %h, required %h", quo, 32'd14); end
    total++; if (rem !== 32'd2)  begin bad++; $display("FAIL hold_rem: got %h, required %h", rem, 32'd2); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL hold_ready: got %b, required 1", ready); end
  endtask

  task automatic test_div_zero();
    issue(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, "div_by_zero");
    wait_done("div_by_zero");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "b2b_first");
    wait_val("b2b_first");
    en  = 1'b1;
    op1 = 32'hFFFF_FFFF;
    op2 = 32'h10;
`ifdef DIVIDER_SIGNED_EN
    e.quo = 32'h0;
    e.rem = 32'hFFFF_FFFF;
`else
    e.quo = 32'h0FFF_FFFF;
    e.rem = 32'hF;
`endif
    e.ovf  = 1'b0;
    e.acc  = cyc + 1;
    e.name = "b2b_second";
    sb.push_back(e);
    @(negedge clk);
    en  = 1'b0;
    op1 = $urandom();
    op2 = $urandom();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL b2b_accept_ready: got %b, required 0", ready); end
    wait_done("b2b_second");
  endtask

  task automatic test_reset_midflight();
    int vals_before;
    issue(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, "aborted");
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if (val !== 1'b0)   begin bad++; $display("FAIL midreset_val: got %b, required 0", val); end
    total++; if (quo !== '0)     begin bad++; $display("FAIL midreset_quo: got %h, required 0", quo); end
    total++; if (rem !== '0)     begin bad++; $display("FAIL midreset_rem: got %h, required 0", rem); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL midreset_ready: got %b, required 1", ready); end
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    vals_before = n_val;
    repeat (40) @(negedge clk);
    total++; if (n_val !== vals_before) begin bad++; $display("FAIL midreset_stale_val: got %0d pulses, required 0", n_val - vals_before); end
    issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, "div_9_3");
    wait_done("div_9_3");
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
    for (int i = 0; i < 8; i++) begin
      a = $urandom();
      b = (i % 2 == 1) ? W'($urandom_range(1, 300)) : W'($urandom());
      e = model(a, b);
      issue(a, b, e.quo, e.rem, e.ovf, $sformatf("rand%0d", i));
    end
    wait_done("random");
  endtask

`ifdef DIVIDER_SIGNED_EN
  task automatic test_signed();
    issue(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "sgn_m7_2");
    issue(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, "sgn_min_m1");
    issue(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, "sgn_7_m2");
    wait_done("signed");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_div_zero();
    test_back_to_back();
    test_reset_midflight();
    test_random();
`ifdef DIVIDER_SIGNED_EN
    test_signed();
`endif
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
